// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - UART receive shared types and sizing helpers; PARITY state exists only with UART_RX_PARITY_EN
package uart_rx_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD, PARITY} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} rx_state_t;
`endif

    function automatic int timer_width(input int clks_per_bit);
        return $clog2(clks_per_bit + 1);
    endfunction

    function automatic int half_period(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - bit-period counter counting 1..rollover, tick on the rollover count
module rx_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= (r_count == rollover_val) ? WIDTH'(1) : r_count + 1'b1;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = count_enable && (r_count == rollover_val);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive deframer with valid/ready output buffer; parity option UART_RX_PARITY_EN
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic                 overrun_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);

    localparam int TW = timer_width(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] ROLL_HALF = TW'(half_period(CLKS_PER_BIT));
    localparam logic [TW-1:0] ROLL_FULL = TW'(CLKS_PER_BIT);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_next;
    logic [1:0]           r_sync;
    logic                 w_s_in;
    logic [DATA_BITS-1:0] r_shift;
    logic [IW-1:0]        r_bit_idx;
    logic                 w_clear;
    logic                 w_enable;
    logic                 w_tick;
    logic [TW-1:0]        w_rollover;
    logic                 w_load_evt;
    logic                 w_par_ok;
    logic                 w_good_load;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], serial_in};
        end
    end
    assign w_s_in = r_sync[1];

    assign w_rollover = (r_state == START) ? ROLL_HALF : ROLL_FULL;

    rx_bit_timer #(.WIDTH(TW)) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_clear),
        .count_enable (w_enable),
        .rollover_val (w_rollover),
        .count_out    (),
        .rollover_flag(w_tick)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The timer also runs on the detection cycle and is not cleared leaving START:
    // its natural wrap to 1 aligns data sampling to mid-bit.
    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_enable = 1'b1;
        case (r_state)
            IDLE: begin
                w_enable = !w_s_in;
                w_clear  = w_s_in;
                if (!w_s_in) w_next = START;
            end
            START: begin
                if (w_tick) begin
                    if (w_s_in) begin
                        w_next  = IDLE;
                        w_clear = 1'b1;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_tick && (r_bit_idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick) w_next = STOP;
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_next  = LOAD;
                    w_clear = 1'b1;
                end
            end
            LOAD: begin
                w_enable = 1'b0;
                w_clear  = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else begin
            if (r_state == START && w_tick) begin
                r_bit_idx <= '0;
            end else if (r_state == DATA && w_tick) begin
                r_shift   <= {w_s_in, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_parity <= 1'b0;
        end else if (r_state == PARITY && w_tick) begin
            r_parity <= w_s_in;
        end
    end
    assign w_par_ok = ~(^{r_shift, r_parity});
`else
    assign w_par_ok = 1'b1;
`endif

    // Output registers update on the stop-bit tick so the word is visible as LOAD is entered.
    assign w_load_evt  = (r_state == STOP) && w_tick;
    assign w_good_load = w_load_evt && w_s_in && w_par_ok;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            overrun_error <= w_good_load && rx_valid && !rx_ready;
            if (w_good_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (w_load_evt) framing_error <= !w_s_in;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_error <= 1'b0;
        end else if (w_load_evt) begin
            parity_error <= !w_par_ok;
        end
    end
`endif

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame (CLKS_PER_BIT=10, DATA_BITS=8)
module tb_uart_rx_frame;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       serial_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         t_start = 0;
    int         ev_cyc = 0;
    int         n_overrun = 0;
    int         n_events = 0;
    logic       busy_mid = 1'b0;
    logic       ready_at_edge = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ovr = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        ready_at_edge <= rx_ready;
    end

    // A new word is present when valid rises, data changes, an overrun fires, or valid survives a transfer.
    always @(negedge clk) begin
        if (rx_valid && (!prev_valid || ready_at_edge || overrun_error || rx_data != prev_data)) begin
            n_events++;
            ev_cyc = cyc;
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("rx_data_sb", rx_data, exp_q.pop_front());
        end
        if (overrun_error) begin
            n_overrun++;
            check("overrun_single", prev_ovr, 0);
        end
        prev_valid = rx_valid;
        prev_data  = rx_data;
        prev_ovr   = overrun_error;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        idle(C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        logic good;
`ifdef UART_RX_PARITY_EN
        good = stop_b && !par_flip;
`else
        good = stop_b && (par_flip == par_flip);
`endif
        if (good) exp_q.push_back(d);
        @(posedge clk);
        #1;
        t_start = cyc;
        drive_bit(1'b0);
        busy_mid = busy;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
        serial_in = 1'b1;
    endtask

    task automatic consume();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("valid_after_consume", rx_valid, 0);
    endtask

    task automatic ack_first();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_valid) break;
        end
        check("ack_seen_valid", rx_valid, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        int ev0;
        serial_in = 1'b1;
        rx_ready  = 1'b0;
        n_rst     = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        idle(50);
        @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_framing", framing_error, 0);
        check("reset_overrun", overrun_error, 0);
        check("reset_data", rx_data, 0);
`ifdef UART_RX_PARITY_EN
        check("reset_parity", parity_error, 0);
`endif

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(5);
        check("a5_latency", ev_cyc - t_start, 98);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_framing", framing_error, 0);
        check("a5_busy_mid", busy_mid, 1);
        check("a5_busy_end", busy, 0);
        consume();

        ev0 = n_events;
        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        check("glitch_busy", busy, 1);
        idle(20);
        check("glitch_busy_end", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_no_word", n_events - ev0, 0);

        send_frame(8'h3C, 1'b0, 1'b0);
        idle(5);
        check("bad_stop_valid", rx_valid, 0);
        check("bad_stop_framing", framing_error, 1);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(5);
        check("11_framing", framing_error, 0);
        check("11_data", rx_data, 8'h11);
        check("11_valid", rx_valid, 1);
        consume();

        ov0 = n_overrun;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        idle(5);
        check("overrun_count", n_overrun - ov0, 1);
        check("overrun_data", rx_data, 8'h02);
        check("overrun_valid", rx_valid, 1);
        consume();

        ov0 = n_overrun;
        fork
            begin
                send_frame(8'h01, 1'b1, 1'b0);
                send_frame(8'h02, 1'b1, 1'b0);
            end
            ack_first();
        join
        idle(5);
        check("no_overrun_count", n_overrun - ov0, 0);
        check("no_overrun_data", rx_data, 8'h02);
        check("no_overrun_valid", rx_valid, 1);
        consume();

        @(posedge clk);
        #1 serial_in = 1'b0;
        idle(40);
        n_rst = 1'b0;
        #1;
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_framing", framing_error, 0);
        check("midrst_overrun", overrun_error, 0);
        serial_in = 1'b1;
        @(posedge clk);
        #1 n_rst = 1'b1;
        idle(10);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(5);
        check("7e_data", rx_data, 8'h7E);
        check("7e_valid", rx_valid, 1);
        consume();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(5);
        check("par_error", parity_error, 1);
        check("par_framing", framing_error, 0);
        check("par_discard", rx_valid, 0);
`endif

        idle(5);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
